// File: rtl/booth4_multiplier_fp32.sv
// booth4_multiplier_fp32: iterative IEEE-754 single-precision multiplier.
// The multiplier mantissa is recoded into radix-4 signed digits {-2..+2}
// (3-bit {sign, mag} encoding shared with the SRT divider's quotient digits),
// one digit is accumulated per cycle, then the product is normalized,
// rounded and packed. Subnormal inputs flush to zero; no subnormal outputs.
// Optional feature macro: BOOTH_MUL_RNE_EN selects round-to-nearest-even;
// without it the result is truncated (round toward zero).
module booth4_multiplier_fp32 (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] multiplicand,
  input  logic [31:0] multiplier,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] product
);

  typedef enum logic [2:0] {IDLE, MUL, NORM, PACK, DONE} state_t;

  state_t             state_q;
  logic signed [49:0] acc_q;
  logic [3:0]         cnt_q;
  logic [23:0]        mantA_q;
  logic [26:0]        recode_q;
  logic               sign_q;
  logic signed [9:0]  exp_q;
  logic               nan_q;
  logic               inf_q;
  logic               zero_q;
  logic [22:0]        mant_q;
  logic [31:0]        product_q;
  logic               outValid_q;
`ifdef BOOTH_MUL_RNE_EN
  logic               guard_q;
  logic               sticky_q;
`endif

  logic [2:0]         digit;
  logic [25:0]        multMag;
  logic signed [25:0] term;
  logic signed [51:0] accSum;
  logic signed [49:0] acc_d;
  logic               roundInc;
  logic [23:0]        mantRounded;
  logic signed [9:0]  expRounded;
  logic [22:0]        fracFinal;
  logic [31:0]        packed_d;

  // Operand classification of the incoming pair
  logic zeroA, zeroB, infA, infB, nanA, nanB;
  assign zeroA = (multiplicand[30:23] == 8'd0);
  assign zeroB = (multiplier[30:23] == 8'd0);
  assign infA  = (multiplicand[30:23] == 8'hFF) && (multiplicand[22:0] == 23'd0);
  assign infB  = (multiplier[30:23] == 8'hFF) && (multiplier[22:0] == 23'd0);
  assign nanA  = (multiplicand[30:23] == 8'hFF) && (multiplicand[22:0] != 23'd0);
  assign nanB  = (multiplier[30:23] == 8'hFF) && (multiplier[22:0] != 23'd0);

  assign in_ready  = (state_q == IDLE);
  assign out_valid = outValid_q;
  assign product   = product_q;

  // Booth step: recode the low triple, form digit x A and add it at the top before the 2-bit arithmetic shift
  always_comb begin
    digit = 3'b000;
    unique case (recode_q[2:0])
      3'b001, 3'b010: digit = 3'b001;
      3'b011:         digit = 3'b010;
      3'b100:         digit = 3'b110;
      3'b101, 3'b110: digit = 3'b101;
      default:        digit = 3'b000;
    endcase
    multMag = 26'd0;
    if (digit[1:0] == 2'b10)
      multMag = {1'b0, mantA_q, 1'b0};
    else if (digit[1:0] == 2'b01)
      multMag = {2'b00, mantA_q};
    term   = digit[2] ? -$signed(multMag) : $signed(multMag);
    accSum = {{2{acc_q[49]}}, acc_q} + {term, 26'd0};
    acc_d  = accSum[51:2];
  end

  // Rounding of the normalized mantissa followed by the prioritized result rules
  always_comb begin
`ifdef BOOTH_MUL_RNE_EN
    roundInc = guard_q & (sticky_q | mant_q[0]);
`else
    roundInc = 1'b0;
`endif
    mantRounded = {1'b0, mant_q} + {23'd0, roundInc};
    expRounded  = exp_q + (mantRounded[23] ? 10'sd1 : 10'sd0);
    fracFinal   = mantRounded[23] ? 23'd0 : mantRounded[22:0];
    if (nan_q)
      packed_d = 32'h7FC00000;
    else if (inf_q)
      packed_d = {sign_q, 8'hFF, 23'd0};
    else if (zero_q)
      packed_d = {sign_q, 31'd0};
    else if (expRounded >= 10'sd255)
      packed_d = {sign_q, 8'hFF, 23'd0};
    else if (expRounded <= 10'sd0)
      packed_d = {sign_q, 31'd0};
    else
      packed_d = {sign_q, expRounded[7:0], fracFinal};
  end

  // Control FSM and datapath registers; special cases walk the full sequence for uniform latency
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      acc_q      <= '0;
      cnt_q      <= '0;
      mantA_q    <= '0;
      recode_q   <= '0;
      sign_q     <= 1'b0;
      exp_q      <= '0;
      nan_q      <= 1'b0;
      inf_q      <= 1'b0;
      zero_q     <= 1'b0;
      mant_q     <= '0;
      product_q  <= '0;
      outValid_q <= 1'b0;
`ifdef BOOTH_MUL_RNE_EN
      guard_q    <= 1'b0;
      sticky_q   <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            mantA_q  <= {1'b1, multiplicand[22:0]};
            recode_q <= {2'b00, 1'b1, multiplier[22:0], 1'b0};
            sign_q   <= multiplicand[31] ^ multiplier[31];
            exp_q    <= $signed({2'b00, multiplicand[30:23]}) + $signed({2'b00, multiplier[30:23]}) - 10'sd127;
            nan_q    <= nanA | nanB | (infA & zeroB) | (infB & zeroA);
            inf_q    <= infA | infB;
            zero_q   <= zeroA | zeroB;
            acc_q    <= '0;
            cnt_q    <= '0;
            state_q  <= MUL;
          end
        end
        MUL: begin
          acc_q    <= acc_d;
          recode_q <= recode_q >> 2;
          cnt_q    <= cnt_q + 4'd1;
          if (cnt_q == 4'd12)
            state_q <= NORM;
        end
        NORM: begin
          if (acc_q[47]) begin
            mant_q   <= acc_q[46:24];
            exp_q    <= exp_q + 10'sd1;
`ifdef BOOTH_MUL_RNE_EN
            guard_q  <= acc_q[23];
            sticky_q <= |acc_q[22:0];
`endif
          end else begin
            mant_q   <= acc_q[45:23];
`ifdef BOOTH_MUL_RNE_EN
            guard_q  <= acc_q[22];
            sticky_q <= |acc_q[21:0];
`endif
          end
          state_q <= PACK;
        end
        PACK: begin
          product_q  <= packed_d;
          outValid_q <= 1'b1;
          state_q    <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            outValid_q <= 1'b0;
            state_q    <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_booth4_multiplier_fp32.sv
// tb_booth4_multiplier_fp32: directed and randomized checks of the FP32
// Booth multiplier against an arithmetic reference model. The rounding mode
// of the model follows BOOTH_MUL_RNE_EN, same as the design.
module tb_booth4_multiplier_fp32;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] multiplicand;
  logic [31:0] multiplier;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] product;

  int errors = 0;
  int checks = 0;
  int lat;
  logic readySeen;

  booth4_multiplier_fp32 dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .product      (product)
  );

  // Free-running clock, period 10
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference product computed with plain integer arithmetic on the real values
  function automatic logic [31:0] refMul(input logic [31:0] a, input logic [31:0] b);
    int unsigned ea, eb;
    longint unsigned p, rem, half, mant;
    int e, shift;
    logic s, za, zb, ia, ib, na, nb;
    ea = a[30:23];
    eb = b[30:23];
    s  = a[31] ^ b[31];
    za = (ea == 0);
    zb = (eb == 0);
    ia = (ea == 255) && (a[22:0] == 0);
    ib = (eb == 255) && (b[22:0] == 0);
    na = (ea == 255) && (a[22:0] != 0);
    nb = (eb == 255) && (b[22:0] != 0);
    if (na || nb || (ia && zb) || (ib && za)) return 32'h7FC00000;
    if (ia || ib) return {s, 8'hFF, 23'd0};
    if (za || zb) return {s, 31'd0};
    p = longint'({1'b1, a[22:0]}) * longint'({1'b1, b[22:0]});
    e = int'(ea) + int'(eb) - 127;
    if (p >= (64'd1 << 47)) begin
      shift = 24;
      e = e + 1;
    end else begin
      shift = 23;
    end
    mant = (p >> shift) & 64'h7FFFFF;
    rem  = p & ((64'd1 << shift) - 1);
    half = 64'd1 << (shift - 1);
`ifdef BOOTH_MUL_RNE_EN
    if (rem > half || (rem == half && mant[0])) mant = mant + 1;
    if (mant == 64'h800000) begin
      mant = 0;
      e = e + 1;
    end
`else
    if (rem > half) mant = mant + 0;
`endif
    if (e >= 255) return {s, 8'hFF, 23'd0};
    if (e <= 0) return {s, 31'd0};
    return {s, 8'(e), 23'(mant)};
  endfunction

  // Single comparison point: counts the check and reports a failure
  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one operand pair and wait (bounded) for the product
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b);
    int waitCnt;
    waitCnt = 0;
    @(negedge clk);
    while (!in_ready && waitCnt < 50) begin
      @(negedge clk);
      waitCnt++;
    end
    multiplicand = a;
    multiplier   = b;
    in_valid     = 1'b1;
    @(negedge clk);
    in_valid  = 1'b0;
    lat       = 1;
    readySeen = 1'b0;
    while (!out_valid && lat < 40) begin
      if (in_ready) readySeen = 1'b1;
      @(negedge clk);
      lat++;
    end
  endtask

  // Check the product, latency and busy handshake, then accept the result
  task automatic checkOutput(input string tag, input logic [31:0] exp);
    check32({tag, " product"}, product, exp);
    check32({tag, " latency"}, 32'(lat), 32'd16);
    check32({tag, " busy in_ready"}, {31'd0, readySeen}, 32'd0);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check32({tag, " in_ready after accept"}, {31'd0, in_ready}, 32'd1);
  endtask

  task automatic runOp(input string tag, input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
    applyStimulus(a, b);
    checkOutput(tag, exp);
  endtask

  // Directed sequence: reset, test-plan vectors, hold, mid-operation reset, random
  initial begin
    logic [31:0] ra, rb;
    logic [31:0] tieExp;
    logic        validLost;
    rst          = 1'b0;
    in_valid     = 1'b0;
    out_ready    = 1'b0;
    multiplicand = '0;
    multiplier   = '0;
    $display("[TB] start");
    repeat (2) @(negedge clk);
    check32("reset in_ready", {31'd0, in_ready}, 32'd1);
    check32("reset out_valid", {31'd0, out_valid}, 32'd0);
    check32("reset product", product, 32'd0);
    rst = 1'b1;

    runOp("1.5x2", 32'h3FC00000, 32'h40000000, 32'h40400000);
    runOp("-2x3", 32'hC0000000, 32'h40400000, 32'hC0C00000);
`ifdef BOOTH_MUL_RNE_EN
    tieExp = 32'h3FC00002;
`else
    tieExp = 32'h3FC00001;
`endif
    runOp("tie", 32'h3F800001, 32'h3FC00000, tieExp);
    runOp("overflow", 32'h7F000000, 32'h7F000000, 32'h7F800000);
    runOp("underflow", 32'h00800000, 32'h00800000, 32'h00000000);
    runOp("negzero", 32'h80000000, 32'h40000000, 32'h80000000);
    runOp("infxzero", 32'h7F800000, 32'h00000000, 32'h7FC00000);
    runOp("nan", 32'h7FC00001, 32'h3F800000, 32'h7FC00000);
    runOp("neginf", 32'hFF800000, 32'h40000000, 32'hFF800000);

    // Hold the result with out_ready low while new operands are offered
    applyStimulus(32'h3FC00000, 32'h40000000);
    check32("hold product", product, 32'h40400000);
    validLost = 1'b0;
    for (int i = 0; i < 10; i++) begin
      multiplicand = 32'h40000000;
      multiplier   = 32'h40400000;
      in_valid     = 1'b1;
      @(negedge clk);
      if (!out_valid || product !== 32'h40400000 || in_ready) validLost = 1'b1;
    end
    check32("hold stable", {31'd0, validLost}, 32'd0);
    check32("hold out_valid", {31'd0, out_valid}, 32'd1);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check32("hold release in_ready", {31'd0, in_ready}, 32'd1);
    check32("hold release out_valid", {31'd0, out_valid}, 32'd0);

    // Reset in the middle of the MUL phase aborts the operation
    multiplicand = 32'h3FC00000;
    multiplier   = 32'h40000000;
    in_valid     = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    check32("abort in_ready", {31'd0, in_ready}, 32'd1);
    check32("abort out_valid", {31'd0, out_valid}, 32'd0);
    check32("abort product", product, 32'd0);
    validLost = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (out_valid) validLost = 1'b1;
    end
    check32("abort no result", {31'd0, validLost}, 32'd0);
    runOp("1x1", 32'h3F800000, 32'h3F800000, 32'h3F800000);

    // Randomized normal-range and unconstrained operands against the model
    for (int i = 0; i < 24; i++) begin
      if (i < 18) begin
        ra = {1'($urandom_range(0, 1)), 8'($urandom_range(40, 215)), 23'($urandom)};
        rb = {1'($urandom_range(0, 1)), 8'($urandom_range(40, 215)), 23'($urandom)};
      end else begin
        ra = $urandom;
        rb = $urandom;
      end
      runOp("random", ra, rb, refMul(ra, rb));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/booth4_multiplier_fp32.md
# booth4_multiplier_fp32

- Iterative IEEE-754 single-precision multiplier; the multiply-side counterpart of the SRT radix-4 FP32 divider.
- Recodes the multiplier mantissa into radix-4 signed digits {-2..+2}, using the same 3-bit sign/magnitude digit encoding the divider's quotient selection produces, and accumulates one digit per cycle.
- Then normalizes, rounds and packs the result.
- Sits beside the divider in the FP datapath behind a valid/ready handshake.

## Interface
Parameters: none.

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  reset; one clock; reset is synchronous and active-low
- in_valid  input  1  operand pair present
- in_ready  output  1  block can accept operands (high only in IDLE)
- multiplicand  input  32  FP32 operand A
- multiplier  input  32  FP32 operand B (Booth-recoded operand)
- out_valid  output  1  product valid; held until accepted
- out_ready  input  1  consumer accepts product
- product  output  32  FP32 result; stable while out_valid high

## Operation
- States: IDLE → MUL → NORM → PACK → DONE → IDLE.
- IDLE:
  - in_ready=1.
  - On in_valid: latch operands, sign = sA^sB, exponent sum eA+eB-127 (10-bit signed), special-case class.
  - Clear the accumulator, load cnt=0, go to MUL.
- Input classes:
  - exp==0 is treated as zero (subnormal inputs flush to zero).
  - exp==255 with frac==0 is inf; exp==255 with frac!=0 is NaN.
- MUL (13 cycles, cnt 0..12):
  - Recode {2'b00, 1.mB, 1'b0} into one radix-4 digit per cycle, LSB first.
  - Digit encoding: {sign, mag[1:0]}, with mag 00=0, 01=1, 10=2.
  - Add digit×{1.mA} into the top of a 50-bit signed accumulator, then arithmetic-shift right by 2.
  - Leave MUL when cnt==12.
- NORM:
  - The 48-bit product P lies in [1,4).
  - If P[47]==1: mantissa = P[46:24], guard = P[23], sticky = |P[22:0], exp += 1.
  - Otherwise: mantissa = P[45:23], guard = P[22], sticky = |P[21:0].
- PACK:
  - Round (see Configuration). A mantissa carry-out sets frac=0 and exp += 1.
  - Then apply result rules in priority order:
    1. NaN input, or inf×zero → 0x7FC00000 (canonical NaN, sign ignored).
    2. inf×nonzero → {sign, 0xFF, 0}.
    3. zero×finite → {sign, 0, 0}.
    4. exp ≥ 255 → {sign, 0xFF, 0} (overflow to inf).
    5. exp ≤ 0 → {sign, 0, 0} (underflow flush; no subnormal outputs).
    6. Otherwise → {sign, exp[7:0], frac}.
- DONE:
  - out_valid=1 and product is registered.
  - On out_ready, return to IDLE.
  - While out_ready is low, hold state and product, and keep in_ready=0.
- Special cases run the full state sequence anyway, so latency is uniform.

## Timing
- Reset values (rst sampled low at an edge):
  - State = IDLE, in_ready=1, out_valid=0, product=0, accumulator and cnt = 0.
- Reset asserted mid-operation aborts the operation. The next cycle shows IDLE values and no result is produced.
- Handshake fire:
  - Input fires when in_valid & in_ready at edge k.
  - MUL occupies edges k+1..k+13, NORM edge k+14, PACK edge k+15.
  - out_valid is high from after edge k+15 (latency 16 cycles).
- Output fires when out_valid & out_ready. in_ready rises the cycle after the fire.
  - Minimum issue interval is 17 cycles; there is no back-to-back overlap.
- in_valid while busy is ignored; no operand is captured.
- in_ready is a combinational decode of state==IDLE. All other outputs are registered.

## Configuration
- BOOTH_MUL_RNE_EN defined: round-to-nearest-even.
  - Increment when guard & (sticky | mantissa[0]).
- Undefined: truncation (round toward zero). guard and sticky are ignored and no rounding carry can occur.
- Special-case, overflow and flush rules are identical in both builds.

## Test plan
- 0x3FC00000 × 0x40000000 (1.5×2.0) → product 0x40400000; out_valid exactly 16 cycles after the input fire; in_ready low throughout.
- 0xC0000000 × 0x40400000 (−2×3) → 0xC0C00000; 0x3F800001 × 0x3FC00000 (tie case) → 0x3FC00002 with BOOTH_MUL_RNE_EN, 0x3FC00001 without.
- 0x7F000000 × 0x7F000000 → 0x7F800000 (overflow); 0x00800000 × 0x00800000 → 0x00000000 (underflow flush); 0x80000000 × 0x40000000 → 0x80000000.
- 0x7F800000 × 0x00000000 → 0x7FC00000; 0x7FC00001 × 0x3F800000 → 0x7FC00000; 0xFF800000 × 0x40000000 → 0xFF800000.
- Hold out_ready low 10 cycles after out_valid → product and out_valid stable, in_ready=0, new in_valid ignored; raise out_ready → in_ready=1 next cycle.
- Drive rst low at cnt==5 in MUL → next cycle in_ready=1, out_valid=0, product=0; a following 1.0×1.0 (0x3F800000 pair) → 0x3F800000.
